// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input, instruction-memory write port and core-control bundle
// master: byte source / observer side; slave: the loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, err
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader: byte stream to little-endian words written into instruction memory
// Holds the core in reset for the whole load and releases it RST_HOLD cycles after the last write.
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RST_HOLD  = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  imem_loader_if.slave bus
);
  localparam int                HOLD_W    = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);
  localparam logic [16:0]       DEPTH_L   = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_HDR0    = 3'd0,
    S_HDR1    = 3'd1,
    S_DATA    = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_count;
  logic [15:0]         r_idx;
  logic [1:0]          r_byte_cnt;
  logic [23:0]         r_word;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;

  logic                w_in_ready;
  logic                w_cpu_reset;
  logic                w_done;
  logic                w_err;
  logic                w_accept;
  logic                w_last_byte;
  logic                w_last_word;
  logic [15:0]         w_hdr_count;

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_hdr_count = {bus.in_data, r_count[7:0]};
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = (r_idx == (r_count - 16'd1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_accept) w_next = S_HDR1;
      end
      S_HDR1: begin
        if (w_accept) begin
          if (w_hdr_count == 16'd0) begin
            w_next = S_RELEASE;
          end else if ({1'b0, w_hdr_count} > DEPTH_L) begin
            w_next = S_ERR;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept && w_last_byte && w_last_word) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (r_hold == HOLD_LAST) w_next = S_DONE;
      end
      default: w_next = r_state;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_cpu_reset = 1'b1;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_HDR0, S_HDR1, S_DATA: w_in_ready = 1'b1;
      S_DONE: begin
        w_cpu_reset = 1'b0;
        w_done      = 1'b1;
      end
      S_ERR:   w_err = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Bytes arrive LSB first; shifting in from the top leaves {b2,b1,b0} ready for the 4th byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= 16'd0;
      r_idx       <= 16'd0;
      r_byte_cnt  <= 2'd0;
      r_word      <= 24'd0;
      r_hold      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_we <= 1'b0;
      if ((r_state == S_HDR0) && w_accept) begin
        r_count[7:0] <= bus.in_data;
      end
      if ((r_state == S_HDR1) && w_accept) begin
        r_count[15:8] <= bus.in_data;
      end
      if ((r_state == S_DATA) && w_accept) begin
        if (w_last_byte) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= BASE_ADDR + {14'd0, r_idx, 2'b00};
          r_mem_wdata <= {bus.in_data, r_word};
          r_idx       <= r_idx + 16'd1;
          r_byte_cnt  <= 2'd0;
        end else begin
          r_word     <= {bus.in_data, r_word[23:8]};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
      end
      if ((r_state == S_RELEASE) && (r_hold != HOLD_LAST)) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.cpu_reset = w_cpu_reset;
  assign bus.done      = w_done;
  assign bus.err       = w_err;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench: two loaders (DEPTH 256 and 4) fed the same byte stream
// A stream-level reference model predicts every output of both instances on every cycle.
module tb_imem_loader;
  typedef logic [7:0] u8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_loader_if if_a ();
  imem_loader_if if_b ();

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .RST_HOLD(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(if_a.slave)
  );
  imem_loader #(.DEPTH(4), .BASE_ADDR(32'h0000_0000), .RST_HOLD(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(if_b.slave)
  );

  wire        o_we   [2];
  wire [31:0] o_addr [2];
  wire [31:0] o_data [2];
  wire        o_rdy  [2];
  wire        o_crst [2];
  wire        o_done [2];
  wire        o_err  [2];
  assign o_we[0] = if_a.mem_we;      assign o_we[1] = if_b.mem_we;
  assign o_addr[0] = if_a.mem_addr;  assign o_addr[1] = if_b.mem_addr;
  assign o_data[0] = if_a.mem_wdata; assign o_data[1] = if_b.mem_wdata;
  assign o_rdy[0] = if_a.in_ready;   assign o_rdy[1] = if_b.in_ready;
  assign o_crst[0] = if_a.cpu_reset; assign o_crst[1] = if_b.cpu_reset;
  assign o_done[0] = if_a.done;      assign o_done[1] = if_b.done;
  assign o_err[0] = if_a.err;        assign o_err[1] = if_b.err;

  // Reference model: mode 0 = loading, 1 = released (done after HOLD+1 cycles), 2 = error.
  localparam int HOLD = 2;
  int          depth  [2] = '{256, 4};
  int          mode   [2];
  int          pos    [2];
  int          nw     [2];
  int          rel_at [2];
  logic [31:0] wacc   [2];
  logic        exp_we [2];
  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  int          we_cnt [2];
  int          tnow;
  int          n_pass;
  int          n_total;

  always @(negedge clk) begin
    if (o_we[0] === 1'b1) we_cnt[0] <= we_cnt[0] + 1;
    if (o_we[1] === 1'b1) we_cnt[1] <= we_cnt[1] + 1;
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d: observed %h expected %h at cycle %0d", tag, d, obs, exp, tnow);
  endtask

  task automatic model_byte(input int d, input u8 by);
    int k;
    if (pos[d] == 0) begin
      nw[d] = int'(by);
    end else if (pos[d] == 1) begin
      nw[d] = nw[d] + 256 * int'(by);
      if (nw[d] == 0) begin
        mode[d]   = 1;
        rel_at[d] = tnow;
      end else if (nw[d] > depth[d]) begin
        mode[d] = 2;
      end
    end else begin
      k = pos[d] - 2;
      wacc[d][(k % 4) * 8 +: 8] = by;
      if (k % 4 == 3) begin
        exp_we[d]   = 1'b1;
        exp_addr[d] = 32'(4 * (k / 4));
        exp_data[d] = wacc[d];
        if (k / 4 == nw[d] - 1) begin
          mode[d]   = 1;
          rel_at[d] = tnow;
        end
      end
    end
    pos[d]++;
  endtask

  task automatic tick(input logic v, input u8 by, input logic r);
    logic exp_done;
    if_a.in_valid = v; if_a.in_data = by;
    if_b.in_valid = v; if_b.in_data = by;
    rst = r;
    @(posedge clk);
    #1;
    tnow++;
    for (int d = 0; d < 2; d++) begin
      exp_we[d] = 1'b0;
      if (r) begin
        mode[d] = 0; pos[d] = 0; nw[d] = 0; wacc[d] = 32'd0;
      end else if (v && mode[d] == 0) begin
        model_byte(d, by);
      end
      exp_done = (mode[d] == 1) && (tnow - rel_at[d] >= HOLD + 1);
      chk("mem_we", d, 32'(o_we[d]), 32'(exp_we[d]));
      chk("in_ready", d, 32'(o_rdy[d]), 32'(mode[d] == 0));
      chk("err", d, 32'(o_err[d]), 32'(mode[d] == 2));
      chk("done", d, 32'(o_done[d]), 32'(exp_done));
      chk("cpu_reset", d, 32'(o_crst[d]), 32'(!exp_done));
      if (exp_we[d]) begin
        chk("mem_addr", d, o_addr[d], exp_addr[d]);
        chk("mem_wdata", d, o_data[d], exp_data[d]);
      end
      if (r) begin
        chk("reset_addr", d, o_addr[d], 32'h0000_0000);
        chk("reset_wdata", d, o_data[d], 32'h0000_0000);
      end
    end
  endtask

  task automatic send(input u8 q[$], input int gap_lo, input int gap_hi);
    foreach (q[i]) begin
      repeat ($urandom_range(gap_hi, gap_lo)) tick(1'b0, u8'($urandom), 1'b0);
      tick(1'b1, q[i], 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, u8'($urandom), 1'b0);
  endtask

  task automatic junk(input int n);
    repeat (n) tick(1'b1, u8'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 8'h00, 1'b1);
    we_cnt[0] = 0;
    we_cnt[1] = 0;
  endtask

  initial begin
    u8  q[$];
    u8  pre[$];
    int n;
    n_pass  = 0;
    n_total = 0;
    tnow    = 0;
    we_cnt  = '{0, 0};
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0; pos[d] = 0; nw[d] = 0; rel_at[d] = 0; wacc[d] = 32'd0; exp_we[d] = 1'b0;
      exp_addr[d] = 32'd0; exp_data[d] = 32'd0;
    end

    do_reset();
    q = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
    send(q, 0, 0);
    idle(5);
    junk(4);
    chk("two_word_pulses", 0, 32'(we_cnt[0]), 32'd2);

    do_reset();
    send(q, 3, 3);
    idle(5);
    chk("gapped_pulses", 0, 32'(we_cnt[0]), 32'd2);
    chk("gapped_pulses", 1, 32'(we_cnt[1]), 32'd2);

    do_reset();
    send('{8'h00, 8'h00}, 0, 0);
    idle(5);
    junk(3);
    chk("zero_pulses", 0, 32'(we_cnt[0]), 32'd0);

    do_reset();
    send('{8'h01, 8'h01}, 0, 0);
    junk(8);
    chk("over_pulses", 0, 32'(we_cnt[0]), 32'd0);

    do_reset();
    send('{8'h02, 8'h00, 8'hAA, 8'hBB}, 0, 0);
    do_reset();
    send('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 0, 0);
    idle(5);
    chk("midreset_pulses", 0, 32'(we_cnt[0]), 32'd1);

    do_reset();
    send('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33}, 0, 0);
    tick(1'b1, 8'h44, 1'b1);
    idle(3);
    chk("pending_write_dropped", 0, 32'(we_cnt[0]), 32'd0);
    chk("pending_write_dropped", 1, 32'(we_cnt[1]), 32'd0);

    for (int c = 4; c <= 5; c++) begin
      do_reset();
      q = {};
      q.push_back(u8'(c));
      q.push_back(8'h00);
      repeat (4 * c) q.push_back(u8'($urandom));
      send(q, 0, 1);
      idle(5);
      junk(2);
    end

    for (int it = 0; it < 40; it++) begin
      do_reset();
      if ($urandom_range(4, 0) == 0) begin
        pre = {};
        repeat ($urandom_range(9, 1)) pre.push_back(u8'($urandom_range(2, 0)));
        send(pre, 0, 1);
        tick(u8'($urandom) < 8'd128, u8'($urandom), 1'b1);
      end
      n = $urandom_range(6, 0);
      q = {};
      q.push_back(u8'(n));
      q.push_back(($urandom_range(9, 0) == 0) ? 8'h01 : 8'h00);
      repeat (4 * n) q.push_back(u8'($urandom));
      send(q, 0, $urandom_range(2, 0));
      idle($urandom_range(6, 4));
      junk($urandom_range(3, 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined RISC-V core. It receives a byte stream and assembles little-endian 32-bit words, then writes them sequentially into instruction memory, which the core only reads. The core is held in reset for the whole load and released a fixed number of cycles after the last word is written. It sits between the host/bench byte source and the instruction-memory write port, and drives the core's `reset`.

## Interface
- `DEPTH`, 256: instruction-memory capacity in 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word written.
- `RST_HOLD`, 2: cycles `cpu_reset` stays high after the last write.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_data` is valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `mem_we`  out  1: one-cycle instruction-memory write strobe.
- `mem_addr`  out  32: byte address of the write, word aligned.
- `mem_wdata`  out  32: word to write.
- `cpu_reset`  out  1: reset to the core, active high.
- `done`  out  1: load complete and core released.
- `err`  out  1: header word count exceeds `DEPTH`.

## Operation
- **Stream format:** 16-bit word count N, low byte first. This is followed by N words of 4 bytes each, least-significant byte first.
- **Byte accept:** a byte is accepted on a rising edge where `in_valid && in_ready`.
- **States:**
  - HDR0: capture count[7:0]; go to HDR1.
  - HDR1: capture count[15:8].
    - N == 0: go to RELEASE.
    - N > DEPTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: shift the byte into the word assembler.
    - 4th byte of a word: issue a write, then increment the word index.
    - After word N-1 is written: go to RELEASE.
  - RELEASE: count down RST_HOLD cycles, then go to DONE.
  - DONE: terminal until `rst`.
  - ERR: terminal until `rst`.
- **`in_ready`:** 1 in HDR0, HDR1 and DATA; 0 in RELEASE, DONE and ERR.
- **Write address:** `mem_addr = BASE_ADDR + 4*index`. The 16-bit word index never exceeds DEPTH-1, so there is no address wrap.
- **`cpu_reset`:** 1 in every state except DONE.
- **`done`:** 1 only in DONE.
- **`err`:** 1 only in ERR. No writes occur in ERR.
- **Byte gaps:** `in_valid` low at any point leaves all state unchanged. Bytes may be separated by any number of idle cycles.
- **Reset, including mid-load:**
  - state := HDR0; word index, byte counter, count and hold counter := 0.
  - Any partially assembled word is discarded.
  - Words already written are not undone. A new header is expected.
- **Output values after a reset edge:**
  - `in_ready` = 1, `cpu_reset` = 1.
  - `mem_we` = 0, `mem_addr` = BASE_ADDR, `mem_wdata` = 0.
  - `done` = 0, `err` = 0.

## Timing
- **Write latency:** `mem_we`, `mem_addr` and `mem_wdata` are registered. The write is visible in the cycle after the edge that accepted the word's 4th byte.
- **Write strobe width:** `mem_we` is high exactly one cycle per word. Back-to-back bytes give at most one write every 4 cycles.
- **RELEASE entry:** RELEASE is entered on the same edge that registers the last write.
- **Release timing:**
  - `cpu_reset` stays 1 for the write cycle plus RST_HOLD further cycles.
  - `cpu_reset` falls and `done` rises on the same edge.
  - With RST_HOLD=2, `done` rises 3 cycles after the edge accepting the final byte.
- **N == 0:** RELEASE is entered on the edge accepting count[15:8]. `done` rises RST_HOLD+1 edges later.
- **ERR entry:** ERR is entered on the edge accepting count[15:8]. `err` and `in_ready`=0 are visible the next cycle.
- **Bytes after the load:** bytes presented while `in_ready`=0 are not consumed and have no effect.
- **Mid-load reset:** `rst` high on any edge overrides all other activity on that edge, including a pending 4th-byte write. No `mem_we` pulse follows that edge.

## Test plan
- **Two-word load:** stream 02 00, EF BE AD DE, 13 00 00 00 with `in_valid` held high. Writes must be (0x0000_0000, 0xDEADBEEF) then (0x0000_0004, 0x0000_0013). `cpu_reset` then falls and `done`=1 three cycles after the last byte is accepted.
- **Gapped stream:** same stream with 3 idle cycles between every byte. Identical write sequence and values; `mem_we` pulses exactly twice.
- **Zero count:** stream 00 00. No `mem_we`; `done`=1 RST_HOLD+1 cycles after the second byte; `in_ready`=0 afterwards.
- **Over-capacity count:** stream 01 01 (N=257) with DEPTH=256. `err`=1, `in_ready`=0, `cpu_reset`=1, no writes. Further bytes are ignored until `rst`.
- **Mid-load reset:** stream 02 00 AA BB, assert `rst` for one cycle, then stream 01 00 78 56 34 12. Exactly one write, (0x0000_0000, 0x12345678), then `done`=1.
- **Last-address check:** with DEPTH=4, stream count 04 00 followed by four words. The last write goes to address 0x0000_000C; `err` stays 0.
